// File: rtl/decode_pkg.sv
// Shared types for the decode queue: instruction classes, opcode/funct encodings
// and the decoded record that is stored per queue entry.
package decode_pkg;

  typedef enum logic [2:0] {
    NOP     = 3'd0,
    ALU_R   = 3'd1,
    ALU_I   = 3'd2,
    LOAD    = 3'd3,
    STORE   = 3'd4,
    BRANCH  = 3'd5,
    JUMP    = 3'd6,
    UNKNOWN = 3'd7
  } decode_class_t;

  typedef enum logic {
    RUN     = 1'b0,
    TRAPPED = 1'b1
  } queue_state_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   instr;
    decode_class_t cls;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [31:0]   imm;
    logic          exc;
  } decoded_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side valid/ready handshakes of the decode queue.
// slave is the queue's view, master is the surrounding pipeline's view.
interface decode_queue_if;
  import decode_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  decode_class_t out_class;
  logic [4:0]    out_rs;
  logic [4:0]    out_rt;
  logic [4:0]    out_rd;
  logic [31:0]   out_imm;
  logic          out_exc;

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_class,
           out_rs, out_rt, out_rd, out_imm, out_exc
  );

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_class,
           out_rs, out_rt, out_rd, out_imm, out_exc
  );

endinterface

// File: rtl/decode_logic.sv
// Combinational decoder: (pc, instr) -> decoded_t record.
// With DECODE_TRAP_EN unrecognised words become UNKNOWN/exc, otherwise a zeroed NOP.
module decode_logic
  import decode_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output decoded_t    rec
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  f_rs;
    logic [4:0]  f_rt;
    logic [4:0]  f_rd;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [3:0]  pc_hi;
    logic        unknown;

    assign opcode = instr[31:26];
    assign f_rs   = instr[25:21];
    assign f_rt   = instr[20:16];
    assign f_rd   = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];
    // Upper nibble of pc+4: it only changes when pc[27:2] is all ones.
    assign pc_hi  = pc[31:28] + {3'b000, &pc[27:2]};

    // NOTE: every field gets a default before the case so no path leaves a latch.
    always_comb begin
        rec       = '0;
        rec.pc    = pc;
        rec.instr = instr;
        rec.cls   = NOP;
        unknown   = 1'b0;

        unique case (opcode)
            OP_SPECIAL: begin
                unique case (funct)
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_SLT, FN_SLL, FN_SRL: begin
                        rec.cls = ALU_R;
                        rec.rs  = f_rs;
                        rec.rt  = f_rt;
                        rec.rd  = f_rd;
                        rec.imm = {27'b0, shamt};
                    end
                    FN_JR: begin
                        rec.cls = JUMP;
                        rec.rs  = f_rs;
                    end
                    default: unknown = 1'b1;
                endcase
            end
            OP_BEQ, OP_BNE: begin
                rec.cls = BRANCH;
                rec.rs  = f_rs;
                rec.rt  = f_rt;
                rec.imm = {{14{imm16[15]}}, imm16, 2'b00};
            end
            OP_J, OP_JAL: begin
                rec.cls = JUMP;
                rec.imm = {pc_hi, instr[25:0], 2'b00};
            end
            OP_ADDIU, OP_SLTI: begin
                rec.cls = ALU_I;
                rec.rs  = f_rs;
                rec.rt  = f_rt;
                rec.imm = sext16(imm16);
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                rec.cls = ALU_I;
                rec.rs  = f_rs;
                rec.rt  = f_rt;
                rec.imm = zext16(imm16);
            end
            OP_LUI: begin
                rec.cls = ALU_I;
                rec.rt  = f_rt;
                rec.imm = {imm16, 16'h0000};
            end
            OP_LW: begin
                rec.cls = LOAD;
                rec.rs  = f_rs;
                rec.rt  = f_rt;
                rec.imm = sext16(imm16);
            end
            OP_SW: begin
                rec.cls = STORE;
                rec.rs  = f_rs;
                rec.rt  = f_rt;
                rec.imm = sext16(imm16);
            end
            default: unknown = 1'b1;
        endcase

`ifdef DECODE_TRAP_EN
        if (unknown) begin
            rec.cls = UNKNOWN;
            rec.exc = 1'b1;
        end
`else
        // Unknown words fall through as the all-zero NOP set up above.
        if (unknown) rec.cls = NOP;
`endif
    end

endmodule

// File: rtl/decode_queue.sv
// Decode stage with a DEPTH-entry FIFO of decoded records between fetch and execute.
// Optional DECODE_TRAP_EN: an unknown instruction traps the input side until flush.
module decode_queue
  import decode_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           flush,
    decode_queue_if.slave  q
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("decode_queue: DEPTH must be a power of two and at least 2");
    end

    decoded_t      dec;
    decoded_t      mem [DEPTH];
    decoded_t      head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          push;
    logic          pop;
    queue_state_t  state_q;
    queue_state_t  state_d;

    decode_logic u_decode (
        .pc    (q.in_pc),
        .instr (q.in_instr),
        .rec   (dec)
    );

    assign full       = (count == CW'(DEPTH));
    assign q.in_ready = !full && (state_q == RUN);
    assign q.out_valid = (count != '0);
    // Flush wins over both handshakes in the same cycle.
    assign push = q.in_valid && q.in_ready && !flush;
    assign pop  = q.out_valid && q.out_ready && !flush;

    // NOTE: storage is reset too, because outputs are read straight from it and must be zero in reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= dec;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= RUN;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = RUN;
        end
`ifdef DECODE_TRAP_EN
        else if (push && dec.exc) begin
            state_d = TRAPPED;
        end
`endif
    end

    assign head        = mem[rd_ptr];
    assign q.out_pc    = head.pc;
    assign q.out_instr = head.instr;
    assign q.out_class = head.cls;
    assign q.out_rs    = head.rs;
    assign q.out_rt    = head.rt;
    assign q.out_rd    = head.rd;
    assign q.out_imm   = head.imm;
    assign q.out_exc   = head.exc;

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (DEPTH=4); the unknown-opcode
// steps follow whichever DECODE_TRAP_EN build is compiled.
module tb_decode_queue;
    import decode_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   instr;
        decode_class_t cls;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
        logic [31:0]   imm;
    } vec_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic flush  = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [6];

    decode_queue_if dq ();

    decode_queue #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .q      (dq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
        dq.in_valid = 1'b1;
        dq.in_pc    = pc;
        dq.in_instr = instr;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input decode_class_t cls, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [31:0] imm, input logic exc);
        check({tag, ".valid"}, 32'(dq.out_valid), 32'd1);
        check({tag, ".pc"},    dq.out_pc, pc);
        check({tag, ".instr"}, dq.out_instr, instr);
        check({tag, ".class"}, 32'(dq.out_class), 32'(cls));
        check({tag, ".rs"},    32'(dq.out_rs), 32'(rs));
        check({tag, ".rt"},    32'(dq.out_rt), 32'(rt));
        check({tag, ".rd"},    32'(dq.out_rd), 32'(rd));
        check({tag, ".imm"},   dq.out_imm, imm);
        check({tag, ".exc"},   32'(dq.out_exc), 32'(exc));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".valid"}, 32'(dq.out_valid), 32'd0);
        check({tag, ".pc"},    dq.out_pc, 32'h0);
        check({tag, ".instr"}, dq.out_instr, 32'h0);
        check({tag, ".class"}, 32'(dq.out_class), 32'(NOP));
        check({tag, ".rs"},    32'(dq.out_rs), 32'd0);
        check({tag, ".rt"},    32'(dq.out_rt), 32'd0);
        check({tag, ".rd"},    32'(dq.out_rd), 32'd0);
        check({tag, ".imm"},   dq.out_imm, 32'h0);
        check({tag, ".exc"},   32'(dq.out_exc), 32'd0);
    endtask

    initial begin
        dq.in_valid  = 1'b0;
        dq.in_pc     = '0;
        dq.in_instr  = '0;
        dq.out_ready = 1'b0;

        vecs[0] = '{32'h0000_0200, 32'h3C01_1234, ALU_I,  5'd0,  5'd1, 5'd0, 32'h1234_0000};
        vecs[1] = '{32'h0000_0204, 32'hAC22_0004, STORE,  5'd1,  5'd2, 5'd0, 32'h0000_0004};
        vecs[2] = '{32'h0000_0208, 32'h03E0_0008, JUMP,   5'd31, 5'd0, 5'd0, 32'h0000_0000};
        vecs[3] = '{32'h0000_020C, 32'h1443_000C, BRANCH, 5'd2,  5'd3, 5'd0, 32'h0000_0030};
        vecs[4] = '{32'h0000_0210, 32'h3062_FF00, ALU_I,  5'd3,  5'd2, 5'd0, 32'h0000_FF00};
        vecs[5] = '{32'h0000_0214, 32'h0002_1080, ALU_R,  5'd0,  5'd2, 5'd2, 32'h0000_0002};

        // Reset state, before any clock edge
        #2;
        check_zero_outputs("reset");
        #20 resetn = 1'b1;
        step();
        check("reset.in_ready", 32'(dq.in_ready), 32'd1);

        // First push: visible the cycle after
        offer(32'hBFC0_0000, 32'h2401_FFFF);
        step();
        dq.in_valid = 1'b0;
        check_head("addiu", 32'hBFC0_0000, 32'h2401_FFFF, ALU_I, 5'd0, 5'd1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        dq.out_ready = 1'b1;
        step();
        dq.out_ready = 1'b0;
        check("addiu.popped", 32'(dq.out_valid), 32'd0);

        // Fill to DEPTH with out_ready low
        offer(32'h0000_0100, 32'h1000_FFFF); step();
        offer(32'h8000_0000, 32'h0800_0010); step();
        offer(32'h0000_0104, 32'h0022_1821); step();
        offer(32'h0000_0108, 32'h8C43_FFF8); step();
        check("full.in_ready", 32'(dq.in_ready), 32'd0);
        check_head("beq", 32'h0000_0100, 32'h1000_FFFF, BRANCH, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0);

        // Push offered alongside a pop while full: must be refused
        offer(32'h0000_010C, 32'h3C01_1234);
        dq.out_ready = 1'b1;
        step();
        dq.in_valid  = 1'b0;
        dq.out_ready = 1'b0;
        check("full_pop.in_ready", 32'(dq.in_ready), 32'd1);
        check_head("j", 32'h8000_0000, 32'h0800_0010, JUMP, 5'd0, 5'd0, 5'd0, 32'h8000_0040, 1'b0);
        dq.out_ready = 1'b1;
        step();
        check_head("addu", 32'h0000_0104, 32'h0022_1821, ALU_R, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
        step();
        check_head("lw", 32'h0000_0108, 32'h8C43_FFF8, LOAD, 5'd2, 5'd3, 5'd0, 32'hFFFF_FFF8, 1'b0);
        step();
        check("refused.empty", 32'(dq.out_valid), 32'd0);

        // Streaming, one per cycle with out_ready held high
        for (int i = 0; i < 6; i++) begin
            offer(vecs[i].pc, vecs[i].instr);
            step();
            check_head($sformatf("stream%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].cls,
                       vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, 1'b0);
        end
        dq.in_valid = 1'b0;
        step();
        dq.out_ready = 1'b0;
        check("stream.drained", 32'(dq.out_valid), 32'd0);

        // Flush while full with a push offered
        for (int i = 0; i < DEPTH; i++) begin
            offer(32'h0000_0300 + 32'(4 * i), 32'h3441_0000 + 32'(i));
            step();
        end
        check("preflush.in_ready", 32'(dq.in_ready), 32'd0);
        offer(32'h0000_03F0, 32'h3441_AAAA);
        flush = 1'b1;
        step();
        flush = 1'b0;
        dq.in_valid = 1'b0;
        check("flush.out_valid", 32'(dq.out_valid), 32'd0);
        check("flush.in_ready", 32'(dq.in_ready), 32'd1);

        // Refill 2*DEPTH in two rounds so both pointers wrap
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                offer(32'h0000_0400 + 32'(16 * r + 4 * i), 32'h3441_0000 + 32'((r * DEPTH + i) * 32'h1111));
                step();
            end
            dq.in_valid = 1'b0;
            check($sformatf("refill%0d.in_ready", r), 32'(dq.in_ready), 32'd0);
            dq.out_ready = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                check_head($sformatf("refill%0d_%0d", r, i), 32'h0000_0400 + 32'(16 * r + 4 * i),
                           32'h3441_0000 + 32'((r * DEPTH + i) * 32'h1111), ALU_I, 5'd2, 5'd1, 5'd0,
                           32'((r * DEPTH + i) * 32'h1111), 1'b0);
                step();
            end
            dq.out_ready = 1'b0;
            check($sformatf("refill%0d.empty", r), 32'(dq.out_valid), 32'd0);
        end

        // Unknown opcode
        offer(32'h0000_0500, 32'hFC00_0000);
        step();
        dq.in_valid = 1'b0;
`ifdef DECODE_TRAP_EN
        check_head("unk", 32'h0000_0500, 32'hFC00_0000, UNKNOWN, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);
        check("unk.in_ready", 32'(dq.in_ready), 32'd0);
        offer(32'h0000_0504, 32'h2401_0001);
        step();
        step();
        check("trapped.in_ready", 32'(dq.in_ready), 32'd0);
        dq.out_ready = 1'b1;
        step();
        dq.out_ready = 1'b0;
        dq.in_valid  = 1'b0;
        check("trapped.drained", 32'(dq.out_valid), 32'd0);
        check("trapped.still", 32'(dq.in_ready), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("trap_flush.in_ready", 32'(dq.in_ready), 32'd1);
`else
        check_head("unk", 32'h0000_0500, 32'hFC00_0000, NOP, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        check("unk.in_ready", 32'(dq.in_ready), 32'd1);
        offer(32'h0000_0504, 32'h2401_0001);
        dq.out_ready = 1'b1;
        step();
        dq.in_valid = 1'b0;
        check_head("after_unk", 32'h0000_0504, 32'h2401_0001, ALU_I, 5'd0, 5'd1, 5'd0, 32'h1, 1'b0);
        step();
        dq.out_ready = 1'b0;
        check("after_unk.empty", 32'(dq.out_valid), 32'd0);
`endif

        // Reset asserted mid-stream
        offer(32'h0000_0600, 32'h2401_FFFF); step();
        offer(32'h0000_0604, 32'h0800_0010); step();
        dq.in_valid = 1'b0;
        check("prereset.valid", 32'(dq.out_valid), 32'd1);
        #3 resetn = 1'b0;
        #1;
        check_zero_outputs("midreset");
        @(negedge clk);
        resetn = 1'b1;
        step();
        check("postreset.in_ready", 32'(dq.in_ready), 32'd1);
        check("postreset.valid", 32'(dq.out_valid), 32'd0);
        offer(32'h0000_0700, 32'h2402_0005);
        step();
        dq.in_valid = 1'b0;
        check_head("postreset", 32'h0000_0700, 32'h2402_0005, ALU_I, 5'd0, 5'd2, 5'd0, 32'h5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Pipelined successor to the single-cycle decode step of the reference CPU. It accepts fetched instructions over a valid/ready handshake and decodes each one into a structured record: class, register fields and extended immediate. Records are held in a parametrised FIFO and presented to the execute stage over a second valid/ready handshake. The block sits between fetch and execute, and flush is the only way it reacts to redirects.

## Interface
- DEPTH, 2, FIFO entries; power of two, ≥2
- clk  in  1  sole clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  block accepts this cycle
- in_pc  in  32  PC of offered instruction
- in_instr  in  32  instruction word
- flush  in  1  discard all contents (redirect)
- out_valid  out  1  head record valid
- out_ready  in  1  execute consumes head
- out_pc  out  32  PC of head record
- out_instr  out  32  raw instruction word
- out_class  out  3  decode_class_t: NOP, ALU_R, ALU_I, LOAD, STORE, BRANCH, JUMP, UNKNOWN
- out_rs, out_rt, out_rd  out  5 each  register fields (zero where unused)
- out_imm  out  32  extended immediate
- out_exc  out  1  reserved-instruction exception flag

## Operation
- Push on in_valid && in_ready. Pop on out_valid && out_ready.
- in_ready = !full && state==RUN. There is no pass-through: a full queue refuses a push even when a pop happens in the same cycle.
- Decode is combinational on in_instr at push time; the decoded record is what gets stored.
- Opcode 0x00 decodes by funct:
  - ADDU 0x21, SUBU 0x23, AND 0x24, OR 0x25, XOR 0x26, SLT 0x2a, SLL 0x00, SRL 0x02 → ALU_R; imm = shamt zero-extended.
  - JR 0x08 → JUMP; imm = 0.
  - Any other funct → UNKNOWN.
- Other opcodes:
  - BEQ 0x04, BNE 0x05 → BRANCH; imm = sext(imm16)<<2.
  - J 0x02, JAL 0x03 → JUMP; imm = {in_pc+4 [31:28], index26, 2'b00}.
  - ADDIU 0x09, SLTI 0x0a → ALU_I, sign-extended.
  - ANDI 0x0c, ORI 0x0d, XORI 0x0e → ALU_I, zero-extended.
  - LUI 0x0f → ALU_I; imm = {imm16, 16'b0}.
  - LW 0x23 → LOAD, sign-extended. SW 0x2b → STORE, sign-extended.
  - Any other opcode → UNKNOWN.
- State machine: RUN, TRAPPED. TRAPPED is reachable only with the macro (see Configuration).
- Flush:
  - Highest priority: empties the queue, drops any same-cycle push, forces state to RUN.
  - out_valid is 0 in the next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. The count is $clog2(DEPTH+1) bits.
- Reset:
  - Queue empty, state RUN.
  - All storage zeroed, so out_valid=0, out_class=NOP and every other output is 0.
  - Reset asserted mid-transfer discards everything immediately.

## Timing
- Latency: an instruction pushed at edge N is visible on out_* after N (out_valid=1) when the queue was empty.
- Throughput: 1 per cycle while the queue is neither full nor stalled.
- Outputs are driven from storage, not combinationally from in_*.
- in_ready depends only on registered state. It has no combinational path from out_ready.
- out_* stay stable while out_valid && !out_ready.

## Configuration
- DECODE_TRAP_EN defined:
  - An UNKNOWN record is stored with out_exc=1.
  - Pushing it moves state to TRAPPED, and in_ready stays 0 until flush.
  - Records already queued still drain normally.
- DECODE_TRAP_EN undefined:
  - UNKNOWN is stored as class NOP with rs/rt/rd/imm = 0 and out_exc = 0.
  - The state machine never leaves RUN.

## Structure
- Package decode_pkg holds:
  - decode_class_t
  - opcode and funct localparams
  - decoded_t struct {pc, instr, class, rs, rt, rd, imm, exc}
- Sub-module decode_logic: purely combinational, maps (pc, instr) to decoded_t. It is instantiated once on the input side.

## Test plan
- Reset, then push ADDIU 0x2401FFFF at PC 0xBFC00000 → the next cycle shows out_valid=1, ALU_I, rt=1, imm=0xFFFFFFFF.
- Hold out_ready=0 and push DEPTH instructions → in_ready=0 after the DEPTH-th push, and a further push is refused even with a same-cycle pop.
- BEQ 0x1000FFFF → BRANCH, imm=0xFFFFFFFC. J 0x08000010 at PC 0x80000000 → JUMP, imm=0x80000040.
- Flush while queue is full and in_valid=1 → out_valid=0 the next cycle, the input is dropped, and pointers wrap cleanly on a refill of 2×DEPTH.
- With DECODE_TRAP_EN: push word 0xFC000000 → out_exc=1, class UNKNOWN, in_ready stays 0 until flush. Without the macro: class NOP, out_exc=0, and streaming continues.
- Assert resetn low mid-stream → all outputs read 0 immediately. After release, in_ready=1 on the first edge.
